decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, elastic RV32I/RV32M decode stage between fetch and execute.
- Buffers fetched {instruction, PC} pairs in a DEPTH-entry queue and decodes the queue head.
- Presents a registered control_info bundle under a valid/ready handshake, plus an illegal-instruction flag.
- Supports flush for branch redirect and optional M-extension decode.

Parameters:
- DEPTH, 2, instruction queue entries; power of two, min 2.
- ENABLE_M, 1, when 1 decode mul/mulh/mulhsu/mulhu/div/divu/rem/remu; when 0 those encodings are illegal.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- IN_VALID  in  1  fetch offers INSTRUCTION/PC.
- IN_READY  out  1  queue can accept this cycle.
- INSTRUCTION  in  32  raw instruction word.
- PC  in  32  address of INSTRUCTION.
- FLUSH  in  1  discard all buffered and presented instructions.
- OUT_VALID  out  1  CTR_INFO/ILLEGAL hold a decoded instruction.
- OUT_READY  in  1  execute consumes the presented instruction.
- RS1  out  5  register-file read address for the instruction loaded this cycle.
- RS2  out  5  register-file read address for the instruction loaded this cycle.
- RS_EN  out  1  high when RS1/RS2 are valid (output register loads this cycle).
- CTR_INFO  out  control_info  one-hot op flags, rd, immediate, pc.
- ILLEGAL  out  1  presented instruction is unsupported.
- COUNT  out  CNT_W  current queue occupancy.

Behaviour:
- Reset (RSTN=0 at an edge):
  - Queue emptied, pointers 0, COUNT=0, OUT_VALID=0, ILLEGAL=0.
  - All CTR_INFO flags 0, rd 0, immediate 0, pc 0.
  - IN_READY=1 in the first cycle after reset deasserts.
- Queue:
  - push = IN_VALID & IN_READY; IN_READY = (COUNT < DEPTH).
  - When full, IN_READY stays 0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: COUNT unchanged.
- Load into output register:
  - load = (COUNT != 0) & (!OUT_VALID | OUT_READY) & !FLUSH.
  - On load: the head is popped and its decode is registered into CTR_INFO/ILLEGAL; OUT_VALID becomes 1.
  - If OUT_READY=1 and there is no load, OUT_VALID becomes 0.
  - If OUT_VALID=1 and OUT_READY=0, all outputs hold.
- Latency and throughput:
  - Empty queue: push at cycle N gives OUT_VALID at cycle N+2.
  - Sustained throughput: 1 instruction/cycle.
- RS1/RS2/RS_EN:
  - Combinational from the queue head; RS_EN = load.
  - RS1 = rs1 field for R/I/S/B types, else 0.
  - RS2 = rs2 field for R/S/B types, else 0.
- Decode:
  - Immediates are sign-extended from instruction bit 31.
  - B-type immediate = {imm[12:1],0}; J-type immediate = {imm[20:1],0}; U-type immediate = {instr[31:12],12'b0}.
  - I-type shifts compare instr[31:25] for slli/srli (0000000) and srai (0100000).
  - rd is 0 for S/B types.
- Illegal:
  - Triggers: unknown opcode, undefined funct3/funct7 combination, jalr with funct3≠0, or M-op when ENABLE_M=0.
  - Response: ILLEGAL=1, all op flags 0, rd=0; pc is still valid.
- FLUSH:
  - Next edge: COUNT=0, OUT_VALID=0, ILLEGAL=0.
  - A push in the flush cycle is dropped.
  - FLUSH takes priority over load, push and pop.
  - IN_READY is unaffected by FLUSH in the same cycle.
- Reset mid-stream behaves as flush plus clearing CTR_INFO.

Test Plan:
- Push 0x00500093 (addi x1,x0,5), PC=0x100, OUT_READY=1 -> 2 cycles later OUT_VALID=1, addi=1, rd=1, immediate=5, pc=0x100, RS1=0 during the load cycle.
- Push 0xFE208EE3 (beq x1,x2,-4) -> beq=1, immediate=0xFFFFFFFC, rd=0, RS1=1, RS2=2 with RS_EN=1.
- Push 0x40335293 -> srai=1, srli=0, rd=5, RS1=6, immediate low 5 bits = 3.
- Push 0x022081B3 (mul x3,x1,x2) -> with ENABLE_M=1: mul=1, rd=3, ILLEGAL=0; with ENABLE_M=0: ILLEGAL=1, all flags 0, rd=0.
- DEPTH=2, OUT_READY=0, push 4 instructions -> OUT_VALID=1, COUNT=2, IN_READY=0. Then OUT_READY=1 -> order preserved, one output per cycle, IN_READY returns to 1 after the first pop.
- Queue holds 2 entries, OUT_VALID=1, assert FLUSH with IN_VALID=1 -> next cycle COUNT=0, OUT_VALID=0, pushed word never appears. Then reset mid-stream -> all outputs zero.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32M decode stage: elastic instruction queue feeding a registered
// control bundle under a valid/ready handshake toward execute.

package decode_stage_pkg;

    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu;
        logic sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic fence, ecall, ebreak;
    } op_flags_t;

    typedef struct packed {
        op_flags_t   op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } control_info;

endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [31:0]      PC,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic             RS_EN,
    output control_info      CTR_INFO,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] COUNT
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    control_info      ctr_q, ctr_d;

    logic        push, load;
    logic [31:0] head_instr, head_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    control_info dec;
    logic        dec_ill;

    assign IN_READY   = (count_q != CNT_W'(DEPTH));
    assign push       = IN_VALID & IN_READY & ~FLUSH;
    assign load       = (count_q != '0) & (~out_valid_q | OUT_READY) & ~FLUSH;
    assign RS_EN      = load;

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign funct7     = head_instr[31:25];

    assign OUT_VALID  = out_valid_q;
    assign ILLEGAL    = illegal_q;
    assign CTR_INFO   = ctr_q;
    assign COUNT      = count_q;

    // Register-file read addresses straight from the queue head.
    always_comb begin
        RS1 = '0;
        RS2 = '0;
        unique case (opcode)
            OPC_OP, OPC_BRANCH, OPC_STORE: begin
                RS1 = head_instr[19:15];
                RS2 = head_instr[24:20];
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: RS1 = head_instr[19:15];
            default: ;
        endcase
    end

    // Decode the queue head into the control bundle and legality flag.
    always_comb begin
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
        imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                 head_instr[30:25], head_instr[11:8], 1'b0};
        imm_u = {head_instr[31:12], 12'b0};
        imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                 head_instr[20], head_instr[30:21], 1'b0};
        dec     = '0;
        dec.pc  = head_pc;
        dec_ill = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                dec.op.lui = 1'b1; dec.rd = head_instr[11:7]; dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.op.auipc = 1'b1; dec.rd = head_instr[11:7]; dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.op.jal = 1'b1; dec.rd = head_instr[11:7]; dec.imm = imm_j;
            end
            OPC_JALR: begin
                dec.op.jalr = (funct3 == 3'b000);
                dec_ill     = (funct3 != 3'b000);
                dec.rd      = head_instr[11:7];
                dec.imm     = imm_i;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                unique case (funct3)
                    3'b000:  dec.op.beq  = 1'b1;
                    3'b001:  dec.op.bne  = 1'b1;
                    3'b100:  dec.op.blt  = 1'b1;
                    3'b101:  dec.op.bge  = 1'b1;
                    3'b110:  dec.op.bltu = 1'b1;
                    3'b111:  dec.op.bgeu = 1'b1;
                    default: dec_ill     = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.rd  = head_instr[11:7];
                dec.imm = imm_i;
                unique case (funct3)
                    3'b000:  dec.op.lb  = 1'b1;
                    3'b001:  dec.op.lh  = 1'b1;
                    3'b010:  dec.op.lw  = 1'b1;
                    3'b100:  dec.op.lbu = 1'b1;
                    3'b101:  dec.op.lhu = 1'b1;
                    default: dec_ill    = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.imm = imm_s;
                unique case (funct3)
                    3'b000:  dec.op.sb = 1'b1;
                    3'b001:  dec.op.sh = 1'b1;
                    3'b010:  dec.op.sw = 1'b1;
                    default: dec_ill   = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.rd  = head_instr[11:7];
                dec.imm = imm_i;
                unique case (funct3)
                    3'b000: dec.op.addi  = 1'b1;
                    3'b010: dec.op.slti  = 1'b1;
                    3'b011: dec.op.sltiu = 1'b1;
                    3'b100: dec.op.xori  = 1'b1;
                    3'b110: dec.op.ori   = 1'b1;
                    3'b111: dec.op.andi  = 1'b1;
                    3'b001: begin
                        dec.op.slli = (funct7 == 7'b0000000);
                        dec_ill     = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.op.srli = (funct7 == 7'b0000000);
                        dec.op.srai = (funct7 == 7'b0100000);
                        dec_ill     = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                dec.rd = head_instr[11:7];
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000:  dec.op.add  = 1'b1;
                        3'b001:  dec.op.sll  = 1'b1;
                        3'b010:  dec.op.slt  = 1'b1;
                        3'b011:  dec.op.sltu = 1'b1;
                        3'b100:  dec.op.xor_ = 1'b1;
                        3'b101:  dec.op.srl  = 1'b1;
                        3'b110:  dec.op.or_  = 1'b1;
                        default: dec.op.and_ = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    unique case (funct3)
                        3'b000:  dec.op.sub = 1'b1;
                        3'b101:  dec.op.sra = 1'b1;
                        default: dec_ill    = 1'b1;
                    endcase
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    unique case (funct3)
                        3'b000:  dec.op.mul    = 1'b1;
                        3'b001:  dec.op.mulh   = 1'b1;
                        3'b010:  dec.op.mulhsu = 1'b1;
                        3'b011:  dec.op.mulhu  = 1'b1;
                        3'b100:  dec.op.div    = 1'b1;
                        3'b101:  dec.op.divu   = 1'b1;
                        3'b110:  dec.op.rem    = 1'b1;
                        default: dec.op.remu   = 1'b1;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_FENCE: begin
                dec.op.fence = (funct3 == 3'b000);
                dec_ill      = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                dec.op.ecall  = (head_instr == 32'h0000_0073);
                dec.op.ebreak = (head_instr == 32'h0010_0073);
                dec_ill       = (head_instr != 32'h0000_0073) && (head_instr != 32'h0010_0073);
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings present only the pc; everything else is cleared.
        if (dec_ill) begin
            dec    = '0;
            dec.pc = head_pc;
        end
    end

    // Next-state for queue pointers, occupancy and the output register.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        ctr_d       = ctr_q;
        if (FLUSH) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, load})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
            if (load) begin
                out_valid_d = 1'b1;
                illegal_d   = dec_ill;
                ctr_d       = dec;
            end else if (OUT_READY) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Queue storage; occupancy tracking makes resetting the contents unnecessary.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= INSTRUCTION;
            pc_mem_q[wr_ptr_q]    <= PC;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            ctr_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            ctr_q       <= ctr_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, queue back-pressure,
// flush and mid-stream reset, with a second instance built without RV32M.

module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RSTN, IN_VALID, FLUSH, OUT_READY;
    logic [31:0]      INSTRUCTION, PC;
    logic             IN_READY, OUT_VALID, RS_EN, ILLEGAL;
    logic [4:0]       RS1, RS2;
    control_info      ctr;
    logic [CNT_W-1:0] COUNT;

    logic             nm_in_ready, nm_out_valid, nm_rs_en, nm_illegal;
    logic [4:0]       nm_rs1, nm_rs2;
    control_info      nm_ctr;
    logic [CNT_W-1:0] nm_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTRUCTION(INSTRUCTION), .PC(PC), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .RS1(RS1), .RS2(RS2), .RS_EN(RS_EN),
        .CTR_INFO(ctr), .ILLEGAL(ILLEGAL), .COUNT(COUNT)
    );

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b0)) dut_nm (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(nm_in_ready),
        .INSTRUCTION(INSTRUCTION), .PC(PC), .FLUSH(FLUSH), .OUT_VALID(nm_out_valid),
        .OUT_READY(OUT_READY), .RS1(nm_rs1), .RS2(nm_rs2), .RS_EN(nm_rs_en),
        .CTR_INFO(nm_ctr), .ILLEGAL(nm_illegal), .COUNT(nm_count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word for a single cycle; returns in the cycle it is loaded
    // when the queue was empty and the output register free.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        IN_VALID    = 1'b1;
        INSTRUCTION = instr;
        PC          = pc;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        IN_VALID    = 1'b1;
        INSTRUCTION = instr;
        PC          = pc;
    endtask

    initial begin
        RSTN = 1'b0; IN_VALID = 1'b0; INSTRUCTION = '0; PC = '0;
        FLUSH = 1'b0; OUT_READY = 1'b1;
        repeat (2) tick();

        check_eq("rst_count", 32'(COUNT), 32'd0);
        check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_illegal", 32'(ILLEGAL), 32'd0);
        check_eq("rst_flags", 32'(|ctr.op), 32'd0);
        check_eq("rst_rd", 32'(ctr.rd), 32'd0);
        check_eq("rst_imm", ctr.imm, 32'd0);
        check_eq("rst_pc", ctr.pc, 32'd0);
        RSTN = 1'b1;
        check_eq("rst_in_ready", 32'(IN_READY), 32'd1);
        tick();

        // addi x1,x0,5
        issue(32'h0050_0093, 32'h100);
        check_eq("addi_rs_en", 32'(RS_EN), 32'd1);
        check_eq("addi_rs1", 32'(RS1), 32'd0);
        check_eq("addi_lat_not_yet", 32'(OUT_VALID), 32'd0);
        check_eq("addi_count", 32'(COUNT), 32'd1);
        tick();
        check_eq("addi_out_valid", 32'(OUT_VALID), 32'd1);
        check_eq("addi_flag", 32'(ctr.op.addi), 32'd1);
        check_eq("addi_rd", 32'(ctr.rd), 32'd1);
        check_eq("addi_imm", ctr.imm, 32'd5);
        check_eq("addi_pc", ctr.pc, 32'h100);
        check_eq("addi_illegal", 32'(ILLEGAL), 32'd0);

        // beq x1,x2,-4
        issue(32'hFE20_8EE3, 32'h104);
        check_eq("beq_rs_en", 32'(RS_EN), 32'd1);
        check_eq("beq_rs1", 32'(RS1), 32'd1);
        check_eq("beq_rs2", 32'(RS2), 32'd2);
        tick();
        check_eq("beq_flag", 32'(ctr.op.beq), 32'd1);
        check_eq("beq_imm", ctr.imm, 32'hFFFF_FFFC);
        check_eq("beq_rd", 32'(ctr.rd), 32'd0);
        check_eq("beq_illegal", 32'(ILLEGAL), 32'd0);

        // srai x5,x6,3
        issue(32'h4033_5293, 32'h108);
        check_eq("srai_rs1", 32'(RS1), 32'd6);
        check_eq("srai_rs2", 32'(RS2), 32'd0);
        tick();
        check_eq("srai_flag", 32'(ctr.op.srai), 32'd1);
        check_eq("srai_srli", 32'(ctr.op.srli), 32'd0);
        check_eq("srai_rd", 32'(ctr.rd), 32'd5);
        check_eq("srai_shamt", 32'(ctr.imm[4:0]), 32'd3);

        // mul x3,x1,x2 on both configurations
        issue(32'h0220_81B3, 32'h10C);
        tick();
        check_eq("mul_flag", 32'(ctr.op.mul), 32'd1);
        check_eq("mul_rd", 32'(ctr.rd), 32'd3);
        check_eq("mul_illegal", 32'(ILLEGAL), 32'd0);
        check_eq("mul_nm_illegal", 32'(nm_illegal), 32'd1);
        check_eq("mul_nm_flags", 32'(|nm_ctr.op), 32'd0);
        check_eq("mul_nm_rd", 32'(nm_ctr.rd), 32'd0);
        check_eq("mul_nm_pc", nm_ctr.pc, 32'h10C);

        // lui x1,0x12345
        issue(32'h1234_50B7, 32'h110);
        tick();
        check_eq("lui_flag", 32'(ctr.op.lui), 32'd1);
        check_eq("lui_rd", 32'(ctr.rd), 32'd1);
        check_eq("lui_imm", ctr.imm, 32'h1234_5000);

        // jal x1,+8
        issue(32'h0080_00EF, 32'h114);
        tick();
        check_eq("jal_flag", 32'(ctr.op.jal), 32'd1);
        check_eq("jal_imm", ctr.imm, 32'd8);

        // jalr with funct3=1 is illegal
        issue(32'h0000_90E7, 32'h118);
        tick();
        check_eq("jalr_f3_illegal", 32'(ILLEGAL), 32'd1);
        check_eq("jalr_f3_flags", 32'(|ctr.op), 32'd0);
        check_eq("jalr_f3_rd", 32'(ctr.rd), 32'd0);
        check_eq("jalr_f3_pc", ctr.pc, 32'h118);

        // sub x2,x1,x2
        issue(32'h4020_8133, 32'h11C);
        tick();
        check_eq("sub_flag", 32'(ctr.op.sub), 32'd1);
        check_eq("sub_add", 32'(ctr.op.add), 32'd0);
        check_eq("sub_rd", 32'(ctr.rd), 32'd2);
        tick();

        // Back-pressure: fill the queue, then drain in order.
        OUT_READY = 1'b0;
        offer(32'h0000_0093, 32'h200); tick();
        offer(32'h0010_0093, 32'h204);
        check_eq("bp_ready_1", 32'(IN_READY), 32'd1);
        tick();
        check_eq("bp_valid_1", 32'(OUT_VALID), 32'd1);
        check_eq("bp_pc_0", ctr.pc, 32'h200);
        check_eq("bp_count_1", 32'(COUNT), 32'd1);
        offer(32'h0020_0093, 32'h208); tick();
        offer(32'h0030_0093, 32'h20C);
        check_eq("bp_full_count", 32'(COUNT), 32'd2);
        check_eq("bp_full_ready", 32'(IN_READY), 32'd0);
        check_eq("bp_hold_pc", ctr.pc, 32'h200);
        OUT_READY = 1'b1;
        check_eq("bp_full_ready_pop", 32'(IN_READY), 32'd0);
        tick();
        check_eq("bp_pc_1", ctr.pc, 32'h204);
        check_eq("bp_count_2", 32'(COUNT), 32'd1);
        check_eq("bp_ready_back", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        check_eq("bp_pc_2", ctr.pc, 32'h208);
        tick();
        check_eq("bp_pc_3", ctr.pc, 32'h20C);
        check_eq("bp_imm_3", ctr.imm, 32'd3);
        check_eq("bp_count_3", 32'(COUNT), 32'd0);
        tick();
        check_eq("bp_drained", 32'(OUT_VALID), 32'd0);

        // Flush with a full queue.
        OUT_READY = 1'b0;
        offer(32'h0200_0093, 32'h300); tick();
        offer(32'h0210_0093, 32'h304); tick();
        offer(32'h0220_0093, 32'h308); tick();
        check_eq("fl1_count", 32'(COUNT), 32'd2);
        check_eq("fl1_valid", 32'(OUT_VALID), 32'd1);
        offer(32'h0230_0093, 32'h30C);
        FLUSH = 1'b1;
        check_eq("fl1_ready_held", 32'(IN_READY), 32'd0);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        check_eq("fl1_count_after", 32'(COUNT), 32'd0);
        check_eq("fl1_valid_after", 32'(OUT_VALID), 32'd0);

        // Flush while a push is accepted and an illegal word is presented.
        offer(32'hFFFF_FFFF, 32'h400); tick();
        offer(32'h0240_0093, 32'h404); tick();
        check_eq("fl2_illegal", 32'(ILLEGAL), 32'd1);
        check_eq("fl2_pc", ctr.pc, 32'h400);
        offer(32'h0250_0093, 32'h408);
        FLUSH = 1'b1;
        check_eq("fl2_ready", 32'(IN_READY), 32'd1);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        check_eq("fl2_count", 32'(COUNT), 32'd0);
        check_eq("fl2_valid", 32'(OUT_VALID), 32'd0);
        check_eq("fl2_illegal_clr", 32'(ILLEGAL), 32'd0);
        tick(); tick();
        check_eq("fl2_dropped_valid", 32'(OUT_VALID), 32'd0);
        check_eq("fl2_dropped_count", 32'(COUNT), 32'd0);

        // Reset in the middle of traffic.
        OUT_READY = 1'b0;
        offer(32'h0050_0093, 32'h500); tick();
        offer(32'h0060_0093, 32'h504); tick();
        check_eq("mr_valid_before", 32'(OUT_VALID), 32'd1);
        RSTN = 1'b0;
        tick();
        IN_VALID = 1'b0;
        check_eq("mr_valid", 32'(OUT_VALID), 32'd0);
        check_eq("mr_count", 32'(COUNT), 32'd0);
        check_eq("mr_illegal", 32'(ILLEGAL), 32'd0);
        check_eq("mr_flags", 32'(|ctr.op), 32'd0);
        check_eq("mr_rd", 32'(ctr.rd), 32'd0);
        check_eq("mr_imm", ctr.imm, 32'd0);
        check_eq("mr_pc", ctr.pc, 32'd0);
        RSTN = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
